bram_stream_reader: RTL and testbench

//  Read-side sequencer in front of blockram_single_port (read latency 1, write priority).

---
 rtl/bram_stream_pkg.sv | 12 +
 rtl/stream_skid_buf2.sv | 58 +++++
 rtl/bram_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_bram_stream_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// Shared types and helpers for the BRAM stream reader.
//   rd_state_t : reader FSM states
//   calc_aw    : address width for a given RAM depth (never below 1 bit)
package bram_stream_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} rd_state_t;

   function automatic int calc_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry valid/ready buffer sitting between the RAM read port and the
// output stream. The writer guarantees a free slot before pushing, so there
// is no in_ready; the current occupancy is exported for that decision.
//   clk, rst_n  : clock, async active-low reset
//   flush       : synchronous clear, dominates push/pop
//   in_valid    : push in_data this cycle
//   in_data     : word to push
//   out_valid   : head entry valid
//   out_data    : head entry (stable until popped)
//   out_ready   : consumer pops head when out_valid && out_ready
//   count       : current occupancy 0..2
module stream_skid_buf2 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt;
   logic             pop;

   assign out_valid = (cnt != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign count     = cnt;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (in_valid) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, in_valid} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side sequencer for a single-port block RAM (read latency 1).
// A start command (base_addr, length) streams `length` consecutive words,
// wrapping modulo RAM_DEPTH, out through a 2-entry buffer as valid/ready.
//   clk, rst_n    : clock, async active-low reset
//   start         : command pulse, honoured only in IDLE
//   base_addr     : first address; length : word count 0..RAM_DEPTH
//   abort         : cancel the running transfer (RUN/DRAIN)
//   busy, done    : transfer active / 1-cycle end pulse
//   ram_address, ram_read_en, ram_write_en (tied 0), ram_data_out : RAM side
//   m_valid, m_data, m_ready : output stream
// Optional macro BRAM_STREAM_READER_LOOP_EN adds input loop_mode (latched at
// start): the block is re-read from base_addr until aborted.
module bram_stream_reader
   import bram_stream_pkg::*;
#(
   parameter  int RAM_WIDTH = 16,
   parameter  int RAM_DEPTH = 1024,
   localparam int AW        = calc_aw(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW:0]          length,
   input  logic                 abort,
`ifdef BRAM_STREAM_READER_LOOP_EN
   input  logic                 loop_mode,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        ram_address,
   output logic                 ram_read_en,
   output logic                 ram_write_en,
   input  logic [RAM_WIDTH-1:0] ram_data_out,
   output logic                 m_valid,
   output logic [RAM_WIDTH-1:0] m_data,
   input  logic                 m_ready
);

   rd_state_t     state, state_nxt;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_inc;
   logic [AW:0]   remain_q;
   logic          inflight_q;   // read issued last cycle; its word is on ram_data_out now
   logic          loop_q;
   logic          flush;
   logic          pop;
   logic [1:0]    buf_cnt;
   logic [1:0]    occ_after;
   logic          room;
   logic          last_issue;

   assign ram_write_en = 1'b0;
   assign ram_address  = addr_q;
   assign addr_inc     = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
   assign last_issue   = (remain_q == {{AW{1'b0}}, 1'b1});

   // Occupancy counts a same-cycle pop as already gone; this keeps a word
   // issued every cycle while the consumer drains, and the buffer still
   // never exceeds two entries when the issued word lands next cycle.
   assign pop       = m_valid & m_ready;
   assign occ_after = buf_cnt - {1'b0, pop};
   assign room      = (occ_after + {1'b0, inflight_q}) < 2'd2;

`ifdef BRAM_STREAM_READER_LOOP_EN
   logic [AW-1:0] base_q;
   logic [AW:0]   len_q;
`else
   assign loop_q = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and outputs
   always_comb begin
      state_nxt   = state;
      ram_read_en = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      flush       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (length == '0) ? FIN : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (abort) begin
               flush     = 1'b1;
               state_nxt = FIN;
            end else begin
               ram_read_en = room && (remain_q != '0);
               if (ram_read_en && last_issue && !loop_q) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               flush     = 1'b1;
               state_nxt = FIN;
            end else if (!inflight_q && occ_after == 2'd0) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address / remaining counters and in-flight flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         // ram_read_en is low whenever flush is high, so an aborted
         // in-flight word is simply never captured.
         inflight_q <= ram_read_en;
         if (state == IDLE && start) begin
            addr_q   <= base_addr;
            remain_q <= length;
         end else if (ram_read_en) begin
`ifdef BRAM_STREAM_READER_LOOP_EN
            if (last_issue && loop_q) begin
               addr_q   <= base_q;
               remain_q <= len_q;
            end else begin
               addr_q   <= addr_inc;
               remain_q <= remain_q - 1'b1;
            end
`else
            addr_q   <= addr_inc;
            remain_q <= remain_q - 1'b1;
`endif
         end
      end
   end

`ifdef BRAM_STREAM_READER_LOOP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         len_q  <= '0;
         loop_q <= 1'b0;
      end else if (state == IDLE && start) begin
         base_q <= base_addr;
         len_q  <= length;
         loop_q <= loop_mode;
      end
   end
`endif

   stream_skid_buf2 #(.WIDTH(RAM_WIDTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (inflight_q),
      .in_data   (ram_data_out),
      .out_valid (m_valid),
      .out_data  (m_data),
      .out_ready (m_ready),
      .count     (buf_cnt)
   );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader with a 16-word single-port RAM model
// (read latency 1, write priority). RAM is preloaded with ram[i] = 0x100+i.
// Cycle numbering inside a transfer: the start pulse is driven in cycle 0
// and sampled at the edge closing it; RUN issues the first read in cycle 1,
// RAM data appears in cycle 2, the buffer head is valid in cycle 3.
module tb_bram_stream_reader;

   localparam int W  = 16;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          abort;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_address;
   logic          ram_read_en;
   logic          ram_write_en;
   logic [W-1:0]  ram_data_out;
   logic          m_valid;
   logic [W-1:0]  m_data;
   logic          m_ready;
`ifdef BRAM_STREAM_READER_LOOP_EN
   logic          loop_mode;
`endif

   always #5 clk = ~clk;

   bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .base_addr    (base_addr),
      .length       (length),
      .abort        (abort),
`ifdef BRAM_STREAM_READER_LOOP_EN
      .loop_mode    (loop_mode),
`endif
      .busy         (busy),
      .done         (done),
      .ram_address  (ram_address),
      .ram_read_en  (ram_read_en),
      .ram_write_en (ram_write_en),
      .ram_data_out (ram_data_out),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready)
   );

   // RAM model with a preload mux on the write port
   logic [W-1:0]  ram [D];
   logic          preload;
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [W-1:0]  pre_din;
   logic          r_we;
   logic          r_en;
   logic [AW-1:0] r_addr;

   assign r_we   = preload ? pre_we   : ram_write_en;
   assign r_en   = preload ? 1'b0     : ram_read_en;
   assign r_addr = preload ? pre_addr : ram_address;

   always @(posedge clk) begin
      if (r_we)      ram[r_addr]  <= pre_din;
      else if (r_en) ram_data_out <= ram[r_addr];
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0]         base;
      logic [4:0]         len;
      int                 mode;   // 0: m_ready held 1; 1: toggle, then 5-cycle stall
      int                 fv;     // expected first-valid cycle, -1 = not checked
      logic [0:15][15:0]  exp;
   } vec_t;

   function automatic logic rdy(input int mode, input int i);
      if (mode == 0) return 1'b1;
      if (i < 8)     return (i % 2 == 0);
      if (i < 13)    return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_xfer(input string nm, input logic [3:0] b, input logic [4:0] n,
                           input int mode, input int fv, input logic [0:15][15:0] exp);
      int          beats;
      int          first_v;
      int          last_b;
      int          done_c;
      logic        prev_stall;
      logic [15:0] prev_d;
      beats = 0; first_v = -1; last_b = -1; done_c = -1; prev_stall = 1'b0; prev_d = '0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; length = n; m_ready = rdy(mode, 0);
      #1;
      for (int i = 1; i < 80 && done_c < 0; i++) begin
         @(posedge clk); #1;
         start = 1'b0; m_ready = rdy(mode, i);
         #1;
         if (prev_stall) begin
            chk({nm, " stall valid"}, {31'd0, m_valid}, 32'd1);
            chk({nm, " stall data"}, {16'd0, m_data}, {16'd0, prev_d});
         end
         if (m_valid && first_v < 0) first_v = i;
         if (m_valid && m_ready) begin
            if (beats < int'(n)) chk($sformatf("%s beat%0d", nm, beats), {16'd0, m_data}, {16'd0, exp[beats]});
            else                 chk({nm, " extra beat"}, beats, {27'd0, n});
            beats++;
            last_b = i;
         end
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
         if (done) done_c = i;
      end
      chk({nm, " beat count"}, beats, {27'd0, n});
      if (fv >= 0) chk({nm, " first valid cycle"}, first_v, fv);
      chk({nm, " done cycle"}, done_c, last_b + 1);
      @(posedge clk); #2;
      chk({nm, " done single pulse"}, {31'd0, done}, 32'd0);
      chk({nm, " idle busy"}, {31'd0, busy}, 32'd0);
   endtask

   vec_t vec [4];
   logic seen_rd;
   logic seen_v;

   initial begin
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
      base_addr = '0; length = '0;
      preload = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_din = '0;
`ifdef BRAM_STREAM_READER_LOOP_EN
      loop_mode = 1'b0;
`endif
      #3 rst_n = 1'b0;
      #2;
      chk("reset busy",     {31'd0, busy},        32'd0);
      chk("reset done",     {31'd0, done},        32'd0);
      chk("reset read_en",  {31'd0, ram_read_en}, 32'd0);
      chk("reset write_en", {31'd0, ram_write_en},32'd0);
      chk("reset address",  {28'd0, ram_address}, 32'd0);
      chk("reset m_valid",  {31'd0, m_valid},     32'd0);
      chk("reset m_data",   {16'd0, m_data},      32'd0);

      for (int i = 0; i < D; i++) begin
         @(posedge clk); #1;
         pre_we = 1'b1; pre_addr = AW'(i); pre_din = 16'h100 + 16'(i);
      end
      @(posedge clk); #1;
      pre_we = 1'b0; preload = 1'b0;
      rst_n = 1'b1;

      vec[0] = '{4'd3,  5'd4,  0, 3,  {16'h103, 16'h104, 16'h105, 16'h106, {12{16'h0}}}};
      vec[1] = '{4'd14, 5'd4,  0, 3,  {16'h10E, 16'h10F, 16'h100, 16'h101, {12{16'h0}}}};
      vec[2] = '{4'd6,  5'd5,  1, -1, {16'h106, 16'h107, 16'h108, 16'h109, 16'h10A, {11{16'h0}}}};
      vec[3] = '{4'd15, 5'd16, 0, 3,  {16'h10F, 16'h100, 16'h101, 16'h102, 16'h103, 16'h104,
                                       16'h105, 16'h106, 16'h107, 16'h108, 16'h109, 16'h10A,
                                       16'h10B, 16'h10C, 16'h10D, 16'h10E}};
      for (int v = 0; v < 4; v++)
         run_xfer($sformatf("vec%0d", v), vec[v].base, vec[v].len, vec[v].mode, vec[v].fv, vec[v].exp);

      // zero length: done in cycle 1, no read, no data
      seen_rd = 1'b0; seen_v = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd2; length = 5'd0; m_ready = 1'b1;
      #1;
      seen_rd = seen_rd | ram_read_en; seen_v = seen_v | m_valid;
      for (int i = 1; i < 5; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         #1;
         seen_rd = seen_rd | ram_read_en; seen_v = seen_v | m_valid;
         if (i == 1) chk("len0 done", {31'd0, done}, 32'd1);
         if (i == 2) chk("len0 done pulse", {31'd0, done}, 32'd0);
      end
      chk("len0 read_en", {31'd0, seen_rd}, 32'd0);
      chk("len0 m_valid", {31'd0, seen_v},  32'd0);

      // abort on 3rd beat (cycle 5, word 0x106)
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd4; length = 5'd8; m_ready = 1'b1;
      #1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         start = 1'b0; abort = (i == 5);
         #1;
         if (i == 5) begin
            chk("abort 3rd beat valid", {31'd0, m_valid}, 32'd1);
            chk("abort 3rd beat data",  {16'd0, m_data},  32'h106);
         end
      end
      @(posedge clk); #1;
      abort = 1'b0;
      #1;
      chk("abort m_valid",  {31'd0, m_valid},     32'd0);
      chk("abort read_en",  {31'd0, ram_read_en}, 32'd0);
      chk("abort done",     {31'd0, done},        32'd1);
      @(posedge clk); #2;
      chk("abort busy after", {31'd0, busy}, 32'd0);
      run_xfer("after abort", 4'd0, 5'd2, 0, 3, {16'h100, 16'h101, {14{16'h0}}});

      // async reset in RUN
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd0; length = 5'd8; m_ready = 1'b0;
      #1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst busy",    {31'd0, busy},        32'd0);
      chk("rst done",    {31'd0, done},        32'd0);
      chk("rst read_en", {31'd0, ram_read_en}, 32'd0);
      chk("rst address", {28'd0, ram_address}, 32'd0);
      chk("rst m_valid", {31'd0, m_valid},     32'd0);
      chk("rst m_data",  {16'd0, m_data},      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_xfer("after reset", 4'd9, 5'd3, 0, 3, {16'h109, 16'h10A, 16'h10B, {13{16'h0}}});

`ifdef BRAM_STREAM_READER_LOOP_EN
      begin
         int lb;
         lb = 0;
         @(posedge clk); #1;
         start = 1'b1; base_addr = 4'd5; length = 5'd3; loop_mode = 1'b1; m_ready = 1'b1;
         #1;
         for (int i = 1; i < 40 && lb < 9; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (m_valid && m_ready) begin
               chk($sformatf("loop beat%0d", lb), {16'd0, m_data}, 32'h105 + 32'(lb % 3));
               lb++;
            end
         end
         chk("loop beat count", lb, 9);
         chk("loop still busy", {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0; loop_mode = 1'b0;
         #1;
         chk("loop abort m_valid", {31'd0, m_valid}, 32'd0);
         chk("loop abort done",    {31'd0, done},    32'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
